mem_bus_adapter: RTL and testbench
==================================

Name: mem_bus_adapter

Overview:
- Data-side memory interface for the multicycle RV32I core. It sits directly downstream of the control unit's MEM stage.
- Converts a one-shot load/store request (rden/wren, ALU address, rs2 data, funct3) into a word-aligned, byte-enabled req/ack bus transaction.
- Returns sign- or zero-extended load data, a completion pulse, a busy flag for stalling the FSM, and error flags for misalignment, illegal size, and bus timeout.

Parameters:
- TIMEOUT_CYCLES, default 255: number of cycles in REQ without mem_ack before the transaction aborts; 0 disables the timeout.
- ADDR_W, default 32: address width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_rden  in  1  load request, level; may be a single-cycle pulse.
- cpu_wren  in  1  store request, level; may be a single-cycle pulse.
- cpu_addr  in  ADDR_W  byte address from the ALU.
- cpu_wdata  in  32  store data (rs2).
- cpu_funct3  in  3  access size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- cpu_rdata  out  32  extended load data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high from acceptance until and including the cpu_done cycle.
- cpu_misaligned  out  1  misaligned-access flag, valid with cpu_done.
- cpu_err  out  1  illegal-size, dual-request, or timeout flag, valid with cpu_done.
- mem_req  out  1  bus request; held high until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word address, with bits [1:0] forced to 0.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word.
- mem_ack  in  1  single-cycle acknowledge.

Behaviour:
- Reset: on the clock edge where rst=1, state=IDLE, all outputs=0, timeout counter=0, arm=1.
- Reset has priority over everything, including mid-transaction: mem_req drops at that edge and no cpu_done is generated.

States: IDLE, REQ, DONE.
- Accept rule: in IDLE with arm=1 and (cpu_rden | cpu_wren) high, the request is accepted. At acceptance, addr, funct3, wdata and the direction are captured, arm clears, and cpu_busy rises at the next edge.
- Re-arm rule: arm sets again only after a cycle with both request inputs low. A request held high across completion is therefore never issued twice.
- Early completion (IDLE -> DONE, no bus activity) occurs when any of these holds:
  - both rden and wren are high (cpu_err=1);
  - funct3 is illegal for the direction (loads: 011, 110, 111; stores: anything other than 000/001/010) (cpu_err=1);
  - the access is misaligned: half with addr[0]=1, or word with addr[1:0]!=0 (cpu_misaligned=1).
- Otherwise IDLE -> REQ. mem_req=1 with mem_we, mem_addr, mem_be and mem_wdata stable until ack.
- mem_ack is sampled only while mem_req=1. Ack in the first REQ cycle is legal.
- REQ -> DONE on mem_ack, or when the timeout counter reaches TIMEOUT_CYCLES (abort: mem_req drops, cpu_err=1, cpu_rdata=0).
- DONE: cpu_done=1 for exactly one cycle, then -> IDLE.
- cpu_rdata, cpu_misaligned and cpu_err hold their values until the next acceptance.

Latency:
- Request accepted at edge 0; mem_req high during cycle 1.
- Ack in cycle k gives cpu_done in cycle k+1.
- Early completion gives cpu_done in cycle 1.

Lanes, with o = addr[1:0]:
- Byte: be = 1<<o; wdata = {4{wdata[7:0]}}.
- Half: be = o[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
- Word: be = 1111.
- Loads drive the same be values with mem_we=0.

Load extraction:
- Select the byte or half from lane o of mem_rdata.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Stores return cpu_rdata=0.

Timeout counter: clears on acceptance and increments once per REQ cycle without ack.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x80AABBCC, ack on the first REQ cycle -> mem_addr=0x1000, mem_be=1000, cpu_rdata=0xFFFFFF80, cpu_done in cycle 2.
- SH, addr=0x2002, wdata=0x1234ABCD, ack after 3 wait cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_req stable for 4 cycles, single cpu_done.
- LW, addr=0x0006 -> no mem_req, cpu_done in cycle 1 with cpu_misaligned=1; funct3=011 load -> cpu_err=1.
- cpu_rden held high for 10 cycles, ack immediate -> exactly one bus transaction; after rden drops and pulses again -> a second transaction.
- TIMEOUT_CYCLES=4, no ack -> mem_req high for 4 cycles, then cpu_done with cpu_err=1 and cpu_rdata=0.
- rst asserted in the 2nd REQ cycle -> mem_req=0 and cpu_busy=0 at the next edge, no cpu_done; a late mem_ack is ignored.

Source files
------------

// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter: data-side memory port for the multicycle RV32I core.
// Turns a one-shot load/store request into a word-aligned, byte-enabled
// req/ack bus transaction and returns extended load data plus status flags.
module mem_bus_adapter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rden,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_funct3,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              cpu_misaligned,
  output logic              cpu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_next;
  logic              arm;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  tmo_cnt;

  logic        any_req, accept, dual_req, illegal_f3, misalign;
  logic        early_err, early_mis, early;
  logic        timeout_hit;
  logic [1:0]  offs;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rd_shift, load_ext;
  logic [15:0] rd_half;

  // Request decode: acceptance, early-completion causes and lane placement
  always_comb begin
    any_req    = cpu_rden | cpu_wren;
    accept     = (state == IDLE) && arm && any_req;
    dual_req   = cpu_rden & cpu_wren;
    offs       = cpu_addr[1:0];
    if (cpu_wren) begin
      illegal_f3 = !(cpu_funct3 == 3'b000 || cpu_funct3 == 3'b001 || cpu_funct3 == 3'b010);
    end else begin
      illegal_f3 = (cpu_funct3 == 3'b011 || cpu_funct3 == 3'b110 || cpu_funct3 == 3'b111);
    end
    misalign   = ((cpu_funct3[1:0] == 2'b01) && offs[0]) ||
                 ((cpu_funct3[1:0] == 2'b10) && (offs != 2'b00));
    early_err  = dual_req | illegal_f3;
    early_mis  = !early_err && misalign;
    early      = early_err | early_mis;
    be_calc    = 4'b1111;
    wdata_calc = cpu_wdata;
    case (cpu_funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << offs;
        wdata_calc = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = offs[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{cpu_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = cpu_wdata;
      end
    endcase
  end

  // Load extraction from the lane selected by the captured address
  always_comb begin
    rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    rd_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b101:  load_ext = {16'h0, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: ack has priority over a simultaneous timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = early ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem_ack || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture, arm tracking, timeout counting and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      arm            <= 1'b1;
      addr_q         <= '0;
      funct3_q       <= '0;
      we_q           <= 1'b0;
      be_q           <= '0;
      wdata_q        <= '0;
      tmo_cnt        <= '0;
      cpu_rdata      <= '0;
      cpu_err        <= 1'b0;
      cpu_misaligned <= 1'b0;
    end else begin
      if (accept) begin
        arm            <= 1'b0;
        addr_q         <= cpu_addr;
        funct3_q       <= cpu_funct3;
        we_q           <= cpu_wren;
        be_q           <= be_calc;
        wdata_q        <= wdata_calc;
        tmo_cnt        <= '0;
        cpu_rdata      <= '0;
        cpu_err        <= early_err;
        cpu_misaligned <= early_mis;
      end else if (!any_req) begin
        arm <= 1'b1;
      end
      if (state == REQ) begin
        if (mem_ack) begin
          cpu_rdata <= we_q ? 32'h0 : load_ext;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (timeout_hit) begin
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end
        end
      end
    end
  end

  // Bus and handshake outputs decoded from the current state
  always_comb begin
    mem_req   = (state == REQ);
    mem_we    = (state == REQ) && we_q;
    mem_addr  = (state == REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_be    = (state == REQ) ? be_q : 4'b0000;
    mem_wdata = (state == REQ) ? wdata_q : 32'h0;
    cpu_done  = (state == DONE);
    cpu_busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_bus_adapter.sv
// tb_mem_bus_adapter: directed plus randomized checks of mem_bus_adapter
// against a byte-level reference model of loads, stores and error rules.
module tb_mem_bus_adapter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rden, cpu_wren;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_busy, cpu_misaligned, cpu_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  int tests = 0;
  int fails = 0;

  mem_bus_adapter #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_busy(cpu_busy), .cpu_misaligned(cpu_misaligned),
    .cpu_err(cpu_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference model: byte-level view of the access rules
  function automatic void model(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                input logic [31:0] rword,
                                output logic err, output logic mis, output logic [3:0] be,
                                output logic [31:0] wrep, output logic [31:0] rdata);
    int nbytes, o, base;
    logic illegal;
    logic [31:0] v, mask;
    logic [63:0] sval;
    if (wr) illegal = (f3 > 3'd2);
    else    illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    err    = (rd && wr) || illegal;
    nbytes = 1 << f3[1:0];
    o      = int'(addr % 4);
    mis    = !err && ((o % nbytes) != 0);
    base   = o - (o % nbytes);
    be     = 4'(((1 << nbytes) - 1) << base);
    for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    v    = rword >> (8 * o);
    mask = (nbytes >= 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nbytes)) - 1);
    v    = v & mask;
    if (!f3[2] && nbytes < 4 && v >= 32'(64'd1 << (8 * nbytes - 1))) begin
      sval = {32'h0, v} - (64'd1 << (8 * nbytes));
      v    = sval[31:0];
    end
    rdata = wr ? 32'h0 : v;
  endfunction

  // One full transaction: request at the next edge, optional ack after
  // ackWait wait cycles (ackWait >= TMO means no ack), then result checks
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               input int ackWait, input logic [31:0] rword, input bit keep);
    logic eErr, eMis;
    logic [3:0] eBe;
    logic [31:0] eWrep, eRdata;
    int cyc, reqCycles, expDone, expReq;
    bit early, timedOut;
    model(rd, wr, addr, wdata, f3, rword, eErr, eMis, eBe, eWrep, eRdata);
    early    = eErr || eMis;
    timedOut = !early && (ackWait >= TMO);
    if (early) begin
      expReq = 0; expDone = 1; eRdata = 32'h0;
    end else if (timedOut) begin
      expReq = TMO; expDone = TMO + 1; eRdata = 32'h0; eErr = 1'b1;
    end else begin
      expReq = ackWait + 1; expDone = ackWait + 2;
    end
    cpu_rden = rd; cpu_wren = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_funct3 = f3;
    tick();
    if (!keep) begin
      cpu_rden = 1'b0; cpu_wren = 1'b0;
    end
    cpu_addr = $urandom(); cpu_wdata = $urandom();
    checkOutput("busy_after_accept", 32'(cpu_busy), 32'd1);
    cyc = 1;
    reqCycles = 0;
    while (!cpu_done && cyc < 20) begin
      if (mem_req) begin
        reqCycles++;
        checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
        checkOutput("mem_be", 32'(mem_be), 32'(eBe));
        checkOutput("mem_we", 32'(mem_we), 32'(wr));
        if (wr) checkOutput("mem_wdata", mem_wdata, eWrep);
        if (ackWait < TMO && reqCycles == ackWait + 1) begin
          mem_ack = 1'b1;
          mem_rdata = rword;
        end
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = $urandom();
      cyc++;
    end
    checkOutput("done_cycle", 32'(cyc), 32'(expDone));
    checkOutput("req_cycles", 32'(reqCycles), 32'(expReq));
    checkOutput("done_pulse", 32'(cpu_done), 32'd1);
    checkOutput("busy_at_done", 32'(cpu_busy), 32'd1);
    checkOutput("req_at_done", 32'(mem_req), 32'd0);
    checkOutput("err", 32'(cpu_err), 32'(eErr));
    checkOutput("misaligned", 32'(cpu_misaligned), 32'(eMis));
    checkOutput("rdata", cpu_rdata, eRdata);
    tick();
    checkOutput("done_single", 32'(cpu_done), 32'd0);
    checkOutput("busy_released", 32'(cpu_busy), 32'd0);
    checkOutput("rdata_held", cpu_rdata, eRdata);
    checkOutput("err_held", 32'(cpu_err), 32'(eErr));
  endtask

  // Directed sequence followed by a randomized burst
  initial begin
    logic rd, wr;
    logic [2:0] f3;
    int ackWait;
    rst = 1'b1; cpu_rden = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_funct3 = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    checkOutput("reset_req", 32'(mem_req), 32'd0);
    checkOutput("reset_busy", 32'(cpu_busy), 32'd0);
    checkOutput("reset_done", 32'(cpu_done), 32'd0);
    checkOutput("reset_rdata", cpu_rdata, 32'd0);
    checkOutput("reset_err", 32'(cpu_err), 32'd0);
    rst = 1'b0;
    tick();

    // LB from lane 3, ack on the first REQ cycle
    applyStimulus(1'b1, 1'b0, 32'h1003, 32'h0, 3'b000, 0, 32'h80AABBCC, 1'b0);
    checkOutput("lb_value", cpu_rdata, 32'hFFFFFF80);
    // SH to upper half after three wait cycles
    applyStimulus(1'b0, 1'b1, 32'h2002, 32'h1234ABCD, 3'b001, 3, 32'h0, 1'b0);
    // Misaligned LW and illegal load size
    applyStimulus(1'b1, 1'b0, 32'h0006, 32'h0, 3'b010, 0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0008, 32'h0, 3'b011, 0, 32'h0, 1'b0);
    // Both request lines high at once
    applyStimulus(1'b1, 1'b1, 32'h0010, 32'h55, 3'b010, 0, 32'h0, 1'b0);
    // LHU and LW pass-through
    applyStimulus(1'b1, 1'b0, 32'h0102, 32'h0, 3'b101, 1, 32'hF00DBEEF, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0104, 32'h0, 3'b010, 2, 32'hCAFEF00D, 1'b0);
    // Timeout with no ack
    applyStimulus(1'b1, 1'b0, 32'h0200, 32'h0, 3'b010, TMO + 2, 32'h0, 1'b0);

    // rden held high: only one transaction until it drops
    applyStimulus(1'b1, 1'b0, 32'h0300, 32'h0, 3'b010, 0, 32'h11223344, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("held_no_reissue", 32'(mem_req | cpu_busy), 32'd0);
      tick();
    end
    cpu_rden = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0304, 32'h0, 3'b010, 0, 32'h55667788, 1'b0);

    // Reset in the second REQ cycle, then a late ack
    cpu_rden = 1'b1; cpu_funct3 = 3'b010; cpu_addr = 32'h0400;
    tick();
    cpu_rden = 1'b0;
    checkOutput("rst_req_c1", 32'(mem_req), 32'd1);
    tick();
    checkOutput("rst_req_c2", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mid_busy", 32'(cpu_busy), 32'd0);
    checkOutput("rst_mid_done", 32'(cpu_done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    checkOutput("late_ack_done", 32'(cpu_done), 32'd0);
    checkOutput("late_ack_busy", 32'(cpu_busy), 32'd0);
    tick();
    checkOutput("late_ack_rdata", cpu_rdata, 32'd0);

    // Randomized mix of sizes, offsets, errors and ack delays
    for (int n = 0; n < 60; n++) begin
      rd = $urandom_range(0, 1) == 1;
      wr = !rd;
      if ($urandom_range(0, 11) == 0) begin
        rd = 1'b1; wr = 1'b1;
      end
      f3 = 3'($urandom_range(0, 7));
      ackWait = ($urandom_range(0, 7) == 0) ? TMO + 1 : int'($urandom_range(0, 3));
      applyStimulus(rd, wr, $urandom(), $urandom(), f3, ackWait, $urandom(), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
